regfile_wb_ctrl: RTL and testbench

Writeback controller on the write side of the integer register file. It arbitrates results from the single-cycle ALU path and the long-latency load/store unit (LSU), and drives the register file write port (`rf_we`/`rf_wa`/`rf_wd`) from registered outputs. It also keeps a pending-write scoreboard for LSU destinations and forwards the in-flight write to the decode-stage read logic.

---
 rtl/regfile_wb_ctrl.sv | 133 +++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller for the integer register file write port.
// Arbitrates ALU and LSU results, with a one-entry skid buffer for ALU
// results that lose to the LSU. The controller also keeps a scoreboard of
// registers waiting for an LSU result and forwards the in-flight write to
// the decode-stage read logic.
module regfile_wb_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_alu_valid,
  input  logic [ADDR_WIDTH-1:0] i_alu_rd,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  output logic                  o_alu_ready,
  input  logic                  i_lsu_valid,
  input  logic [ADDR_WIDTH-1:0] i_lsu_rd,
  input  logic [DATA_WIDTH-1:0] i_lsu_data,
  output logic                  o_lsu_ready,
  input  logic                  i_iss_valid,
  input  logic [ADDR_WIDTH-1:0] i_iss_rd,
  output logic                  o_iss_ready,
  input  logic [ADDR_WIDTH-1:0] i_chk_rs1,
  input  logic [ADDR_WIDTH-1:0] i_chk_rs2,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic                  o_rs1_fwd,
  output logic                  o_rs2_fwd,
  output logic [DATA_WIDTH-1:0] o_fwd_data,
  output logic                  o_rf_we,
  output logic [ADDR_WIDTH-1:0] o_rf_wa,
  output logic [DATA_WIDTH-1:0] o_rf_wd,
  output logic                  o_err_waw
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic                  r_skid_vld;
  logic [ADDR_WIDTH-1:0] r_skid_rd;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [NUM_REGS-1:0]   r_pend;
  logic                  r_rf_we;
  logic [ADDR_WIDTH-1:0] r_rf_wa;
  logic [DATA_WIDTH-1:0] r_rf_wd;
  logic                  r_err_waw;

  logic                  w_res_ready;
  logic                  w_iss_ready;
  logic                  w_alu_acc;
  logic                  w_lsu_acc;
  logic                  w_iss_acc;
  logic                  w_skid_load;
  logic                  w_win_vld;
  logic [ADDR_WIDTH-1:0] w_win_rd;
  logic [DATA_WIDTH-1:0] w_win_data;

  // Readies come only from registered state and reset, never from valids.
  assign w_res_ready = i_rst_n & ~r_skid_vld;
  assign w_iss_ready = i_rst_n & (~r_pend[i_iss_rd] | (i_iss_rd == '0));

  assign w_alu_acc   = i_alu_valid & w_res_ready;
  assign w_lsu_acc   = i_lsu_valid & w_res_ready;
  assign w_iss_acc   = i_iss_valid & w_iss_ready;
  assign w_skid_load = w_alu_acc & w_lsu_acc;

  // Pick this cycle's single write: skid entry first, then LSU, then ALU.
  always_comb begin
    w_win_vld  = 1'b0;
    w_win_rd   = r_skid_rd;
    w_win_data = r_skid_data;
    if (r_skid_vld) begin
      w_win_vld  = 1'b1;
    end else if (w_lsu_acc) begin
      w_win_vld  = 1'b1;
      w_win_rd   = i_lsu_rd;
      w_win_data = i_lsu_data;
    end else if (w_alu_acc) begin
      w_win_vld  = 1'b1;
      w_win_rd   = i_alu_rd;
      w_win_data = i_alu_data;
    end
  end

  // Register the write port, skid entry, scoreboard and sticky WAW flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rf_we     <= 1'b0;
      r_rf_wa     <= '0;
      r_rf_wd     <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_rd   <= '0;
      r_skid_data <= '0;
      r_pend      <= '0;
      r_err_waw   <= 1'b0;
    end else begin
      r_rf_we <= w_win_vld & (w_win_rd != '0);
      if (w_win_vld) begin
        r_rf_wa <= w_win_rd;
        r_rf_wd <= w_win_data;
      end
      if (r_skid_vld) begin
        r_skid_vld <= 1'b0;
      end else if (w_skid_load) begin
        r_skid_vld  <= 1'b1;
        r_skid_rd   <= i_alu_rd;
        r_skid_data <= i_alu_data;
      end
      if (w_lsu_acc) begin
        r_pend[i_lsu_rd] <= 1'b0;
      end
      if (w_iss_acc && (i_iss_rd != '0)) begin
        r_pend[i_iss_rd] <= 1'b1;
      end
      if (w_alu_acc && r_pend[i_alu_rd]) begin
        r_err_waw <= 1'b1;
      end
    end
  end

  assign o_alu_ready = w_res_ready;
  assign o_lsu_ready = w_res_ready;
  assign o_iss_ready = w_iss_ready;
  assign o_rs1_busy  = r_pend[i_chk_rs1];
  assign o_rs2_busy  = r_pend[i_chk_rs2];
  assign o_rs1_fwd   = r_rf_we & (r_rf_wa == i_chk_rs1) & (i_chk_rs1 != '0);
  assign o_rs2_fwd   = r_rf_we & (r_rf_wa == i_chk_rs2) & (i_chk_rs2 != '0);
  assign o_fwd_data  = r_rf_wd;
  assign o_rf_we     = r_rf_we;
  assign o_rf_wa     = r_rf_wa;
  assign o_rf_wd     = r_rf_wd;
  assign o_err_waw   = r_err_waw;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Testbench for regfile_wb_ctrl: directed steps followed by random traffic,
// all checked against a queue-based reference model of the writeback rules.
module tb_regfile_wb_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic          clk;
  logic          rstN;
  logic          aluValid;
  logic [AW-1:0] aluRd;
  logic [DW-1:0] aluData;
  logic          aluReady;
  logic          lsuValid;
  logic [AW-1:0] lsuRd;
  logic [DW-1:0] lsuData;
  logic          lsuReady;
  logic          issValid;
  logic [AW-1:0] issRd;
  logic          issReady;
  logic [AW-1:0] chkRs1;
  logic [AW-1:0] chkRs2;
  logic          rs1Busy;
  logic          rs2Busy;
  logic          rs1Fwd;
  logic          rs2Fwd;
  logic [DW-1:0] fwdData;
  logic          rfWe;
  logic [AW-1:0] rfWa;
  logic [DW-1:0] rfWd;
  logic          errWaw;

  int testCount = 0;
  int failCount = 0;

  // Reference model: pending bits per register, a queue of results still
  // waiting for the write port, and the write expected on the port now.
  bit                mPend[NR];
  logic [AW+DW-1:0]  mWaitQ[$];
  bit                mWe;
  logic [AW-1:0]     mWa;
  logic [DW-1:0]     mWd;
  bit                mErr;
  bit                mKnown;

  regfile_wb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_alu_valid (aluValid),
    .i_alu_rd    (aluRd),
    .i_alu_data  (aluData),
    .o_alu_ready (aluReady),
    .i_lsu_valid (lsuValid),
    .i_lsu_rd    (lsuRd),
    .i_lsu_data  (lsuData),
    .o_lsu_ready (lsuReady),
    .i_iss_valid (issValid),
    .i_iss_rd    (issRd),
    .o_iss_ready (issReady),
    .i_chk_rs1   (chkRs1),
    .i_chk_rs2   (chkRs2),
    .o_rs1_busy  (rs1Busy),
    .o_rs2_busy  (rs2Busy),
    .o_rs1_fwd   (rs1Fwd),
    .o_rs2_fwd   (rs2Fwd),
    .o_fwd_data  (fwdData),
    .o_rf_we     (rfWe),
    .o_rf_wa     (rfWa),
    .o_rf_wd     (rfWd),
    .o_err_waw   (errWaw)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check combinational outputs against the model,
  // advance the model across the rising edge, then check registered outputs.
  task automatic applyStimulus(
    input logic r,
    input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
    input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
    input logic iv, input logic [AW-1:0] ird,
    input logic [AW-1:0] c1, input logic [AW-1:0] c2);
    bit eRdy, eIss, aAcc, lAcc, iAcc, hasW;
    logic [AW+DW-1:0] writer;
    logic [AW+DW-1:0] arrivals[$];
    rstN = r; aluValid = av; aluRd = ard; aluData = ad;
    lsuValid = lv; lsuRd = lrd; lsuData = ld;
    issValid = iv; issRd = ird; chkRs1 = c1; chkRs2 = c2;
    #1;
    eRdy = r && (mWaitQ.size() == 0);
    eIss = r && ((ird == 0) || !mPend[ird]);
    checkOutput("alu_ready", aluReady, eRdy);
    checkOutput("lsu_ready", lsuReady, eRdy);
    checkOutput("iss_ready", issReady, eIss);
    if (mKnown) begin
      checkOutput("rs1_busy", rs1Busy, mPend[c1]);
      checkOutput("rs2_busy", rs2Busy, mPend[c2]);
      checkOutput("rs1_fwd", rs1Fwd, mWe && (mWa == c1) && (c1 != 0));
      checkOutput("rs2_fwd", rs2Fwd, mWe && (mWa == c2) && (c2 != 0));
      if (mWe) checkOutput("fwd_data", fwdData, mWd);
    end
    if (!r) begin
      foreach (mPend[i]) mPend[i] = 1'b0;
      mWaitQ.delete();
      mWe = 1'b0; mWa = '0; mWd = '0; mErr = 1'b0;
      mKnown = 1'b1;
    end else begin
      aAcc = av && eRdy;
      lAcc = lv && eRdy;
      iAcc = iv && eIss;
      if (aAcc && mPend[ard]) mErr = 1'b1;
      if (lAcc) arrivals.push_back({lrd, ld});
      if (aAcc) arrivals.push_back({ard, ad});
      hasW = 1'b0;
      writer = '0;
      if (mWaitQ.size() > 0) begin
        writer = mWaitQ.pop_front();
        hasW = 1'b1;
      end else if (arrivals.size() > 0) begin
        writer = arrivals.pop_front();
        hasW = 1'b1;
      end
      while (arrivals.size() > 0) mWaitQ.push_back(arrivals.pop_front());
      if (lAcc) mPend[lrd] = 1'b0;
      if (iAcc && (ird != 0)) mPend[ird] = 1'b1;
      mWe = hasW && (writer[AW+DW-1:DW] != 0);
      if (hasW) begin
        mWa = writer[AW+DW-1:DW];
        mWd = writer[DW-1:0];
      end
    end
    @(posedge clk);
    #1;
    checkOutput("rf_we", rfWe, mWe);
    if (mWe) begin
      checkOutput("rf_wa", rfWa, mWa);
      checkOutput("rf_wd", rfWd, mWd);
    end
    checkOutput("err_waw", errWaw, mErr);
  endtask

  task automatic idle(input logic [AW-1:0] c1, input logic [AW-1:0] c2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, c1, c2);
  endtask

  // Directed test plan followed by randomized traffic with occasional resets.
  initial begin
    mKnown = 1'b0;
    mWe = 1'b0; mWa = '0; mWd = '0; mErr = 1'b0;
    foreach (mPend[i]) mPend[i] = 1'b0;

    // Reset held two cycles with valids asserted
    applyStimulus(0, 1, 5, 32'hAA, 1, 6, 32'hBB, 1, 7, 0, 0);
    applyStimulus(0, 1, 5, 32'hAA, 1, 6, 32'hBB, 1, 7, 0, 0);
    checkOutput("reset_we", rfWe, 0);
    checkOutput("reset_wa", rfWa, 0);
    checkOutput("reset_wd", rfWd, 0);
    checkOutput("reset_err", errWaw, 0);
    idle(0, 0);
    checkOutput("release_alu_ready", aluReady, 1);
    checkOutput("release_iss_ready", issReady, 1);

    // ALU write with forwarding in the following cycle
    applyStimulus(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alu_we", rfWe, 1);
    checkOutput("alu_wa", rfWa, 5);
    checkOutput("alu_wd", rfWd, 32'hDEADBEEF);
    chkRs1 = 5;
    #1;
    checkOutput("alu_rs1_fwd", rs1Fwd, 1);
    checkOutput("alu_fwd_data", fwdData, 32'hDEADBEEF);
    idle(5, 0);

    // ALU/LSU collision: LSU first, stalled cycle, then skidded ALU result
    applyStimulus(1, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0);
    checkOutput("coll_lsu_wa", rfWa, 4);
    checkOutput("coll_lsu_wd", rfWd, 32'h22);
    checkOutput("coll_alu_ready_low", aluReady, 0);
    applyStimulus(1, 1, 8, 32'h55, 1, 9, 32'h66, 0, 0, 0, 0);
    checkOutput("coll_skid_wa", rfWa, 3);
    checkOutput("coll_skid_wd", rfWd, 32'h11);
    idle(0, 0);

    // Scoreboard reserve, WAW stall, clear, and same-cycle set/clear
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 7);
    chkRs2 = 7;
    #1;
    checkOutput("sb_rs2_busy", rs2Busy, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 7);
    applyStimulus(1, 0, 0, 0, 1, 7, 32'h33, 0, 0, 0, 7);
    chkRs2 = 7;
    #1;
    checkOutput("sb_cleared", rs2Busy, 0);
    applyStimulus(1, 0, 0, 0, 1, 7, 32'h44, 1, 7, 0, 7);
    chkRs2 = 7;
    #1;
    checkOutput("sb_set_wins", rs2Busy, 1);
    applyStimulus(1, 0, 0, 0, 1, 7, 32'h45, 0, 0, 0, 7);

    // x0 destinations
    applyStimulus(1, 1, 0, 32'h77, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_no_we", rfWe, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chkRs1 = 0;
    #1;
    checkOutput("x0_not_busy", rs1Busy, 0);

    // WAW error is sticky until reset, and reset flushes the scoreboard
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    applyStimulus(1, 1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0);
    checkOutput("waw_set", errWaw, 1);
    idle(9, 0);
    checkOutput("waw_sticky", errWaw, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    checkOutput("waw_reset", errWaw, 0);
    idle(9, 0);
    checkOutput("flush_pend9", rs1Busy, 0);

    // Random traffic on a small register window to force conflicts
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 39) != 0,
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
